// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module  : serial_arith_pkg
// Brief   : Shared types and constants for the bit-serial arithmetic blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // A 1-bit counter still needs one bit of storage, hence the floor of 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module  : full_subtractor
// Brief   : Single-bit combinational full subtractor: d = x - y - bin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic x_xor_y;

  assign x_xor_y = x ^ y;
  assign d       = x_xor_y ^ bin;
  assign bout    = (~x & y) | (~x_xor_y & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial two's-complement subtractor, diff = a - b - bin, one
//           bit per clock with a start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int                 CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  state_t              state;
  state_t              state_nxt;

  logic [WIDTH-1:0]    sa;
  logic [WIDTH-1:0]    sb;
  logic [WIDTH-2:0]    acc;
  logic                br;
  logic [CNT_BITS-1:0] cnt;
  logic                a_msb;
  logic                b_msb;

  logic                bit_d;
  logic                bit_bout;
  logic [WIDTH-1:0]    result;
  logic                accept;
  logic                last_bit;

  full_subtractor u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // acc only needs WIDTH-1 bits: the final bit is taken straight from the cell.
  assign result   = {bit_d, acc};
  assign accept   = start && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (accept) begin
        sa    <= a;
        sb    <= b;
        br    <= bin;
        cnt   <= '0;
        acc   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == SHIFT) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        br  <= bit_bout;
        acc <= result[WIDTH-1:1];
        cnt <= cnt + CNT_BITS'(1);
      end

      // Results are published only on DONE entry so partial sums never leak out.
      if (last_bit) begin
        diff <= result;
        bout <= bit_bout;
        ovf  <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
        zero <= ~|result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Directed and random self-checking bench for serial_subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic       bin   = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  // Pulses start for one cycle and waits (bounded) for done; ends on the done cycle.
  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bin,
                       output int lat, output int busy_n);
    @(negedge clk);
    a = op_a; b = op_b; bin = op_bin; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, diff, bout, ovf, zero} !== 13'd0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 0", {busy, done, diff, bout, ovf, zero});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, diff, bout, ovf, zero} !== 13'd0) begin
      bad++;
      $display("FAIL reset_idle: got %h want 0", {busy, done, diff, bout, ovf, zero});
    end
  endtask

  task automatic test_basic();
    int lat, bn;
    do_op(8'd100, 8'd37, 1'b0, lat, bn);
    total++;
    if (lat !== 9) begin
      bad++; $display("FAIL basic_latency: got %0d want 9", lat);
    end
    total++;
    if (bn !== 8) begin
      bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bn);
    end
    total++;
    if ({diff, bout, ovf, zero} !== {8'd63, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL basic_result: got %h want %h", {diff, bout, ovf, zero}, {8'd63, 3'b000});
    end
    @(negedge clk);
    total++;
    if ({done, diff} !== {1'b0, 8'd63}) begin
      bad++; $display("FAIL basic_pulse_hold: got done=%b diff=%h want done=0 diff=3f", done, diff);
    end
  endtask

  task automatic test_borrow();
    int lat, bn;
    do_op(8'h00, 8'h01, 1'b0, lat, bn);
    total++;
    if ({diff, bout, ovf, zero} !== {8'hFF, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL borrow_under: got %h want %h", {diff, bout, ovf, zero}, {8'hFF, 3'b100});
    end
    do_op(8'h80, 8'h01, 1'b0, lat, bn);
    total++;
    if ({diff, bout, ovf, zero} !== {8'h7F, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL borrow_ovf: got %h want %h", {diff, bout, ovf, zero}, {8'h7F, 3'b010});
    end
  endtask

  task automatic test_zero();
    int lat, bn;
    do_op(8'h05, 8'h04, 1'b1, lat, bn);
    total++;
    if ({diff, bout, ovf, zero} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL zero_bin: got %h want %h", {diff, bout, ovf, zero}, {8'h00, 3'b001});
    end
    do_op(8'h00, 8'hFF, 1'b1, lat, bn);
    total++;
    if ({diff, bout, ovf, zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL zero_wrap: got %h want %h", {diff, bout, ovf, zero}, {8'h00, 3'b101});
    end
  endtask

  task automatic test_ignore_start();
    int dones, first_done;
    logic [7:0] seen;
    dones = 0; first_done = 0; seen = '0;
    @(negedge clk);
    a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first_done == 0) begin
          first_done = i;
          seen       = diff;
        end
      end
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL ignore_done_count: got %0d want 1", dones);
    end
    total++;
    if ({first_done, seen} !== {32'd9, 8'd63}) begin
      bad++; $display("FAIL ignore_result: got at=%0d diff=%h want at=9 diff=3f", first_done, seen);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bn, dones;
    dones = 0;
    @(negedge clk);
    a = 8'hC3; b = 8'h14; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout, ovf, zero} !== 13'd0) begin
      bad++; $display("FAIL abort_clear: got %h want 0", {busy, done, diff, bout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
    end
    do_op(8'hC3, 8'h14, 1'b0, lat, bn);
    total++;
    if ({lat, diff, bout, ovf, zero} !== {32'd9, 8'hAF, 3'b000}) begin
      bad++; $display("FAIL abort_recover: got lat=%0d %h want lat=9 %h", lat, {diff, bout, ovf, zero}, {8'hAF, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 8'h2A; b = 8'h0F; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20; bin = 1'b1;
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ({lat, diff, bout, ovf, zero} !== {32'd9, 8'h1B, 3'b000}) begin
      bad++; $display("FAIL b2b_first: got lat=%0d %h want lat=9 %h", lat, {diff, bout, ovf, zero}, {8'h1B, 3'b000});
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL b2b_restart: got busy,done=%b want 10", {busy, done});
    end
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ({lat, diff, bout, ovf, zero} !== {32'd9, 8'hEF, 3'b100}) begin
      bad++; $display("FAIL b2b_second: got lat=%0d %h want lat=9 %h", lat, {diff, bout, ovf, zero}, {8'hEF, 3'b100});
    end
  endtask

  task automatic test_random();
    int lat, bn, r;
    logic [7:0] ra, rb, ed;
    logic       rbin, eb, eo, ez;
    for (int n = 0; n < 2000; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      r    = int'(ra) - int'(rb) - int'(rbin);
      ed   = 8'(r);
      eb   = (r < 0);
      eo   = (ra[7] != rb[7]) && (ed[7] != ra[7]);
      ez   = (ed == 8'h00);
      do_op(ra, rb, rbin, lat, bn);
      total++;
      if ({lat, diff, bout, ovf, zero} !== {32'd9, ed, eb, eo, ez}) begin
        bad++;
        $display("FAIL random: a=%h b=%h bin=%b got lat=%0d %h want lat=9 %h",
                 ra, rb, rbin, lat, {diff, bout, ovf, zero}, {ed, eb, eo, ez});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
